// File: rtl/physics_pkg.sv
// physics_pkg: shared types and pair-index helper for the collision pair queue.
package physics_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} cpq_state_t;
   // Row-major position of pair (i,j), j>i, within the flattened upper triangle.
   function automatic int pair_index(input int i, input int j, input int s);
      return i * s - i * (i + 1) / 2 + j - i - 1;
   endfunction
endpackage

// File: rtl/pair_priority_encoder.sv
// pair_priority_encoder: lowest set pair (row-major) of a flattened upper-triangle mask.
module pair_priority_encoder
   import physics_pkg::*;
#(
   parameter int SPRITES = 9,
   parameter int IDX_W = 4,
   parameter int PAIRS = SPRITES * (SPRITES - 1) / 2
) (
   input  logic [PAIRS-1:0] mask,
   output logic             any,
   output logic [IDX_W-1:0] i,
   output logic [IDX_W-1:0] j
);
   logic [PAIRS-1:0] low;
   // Bit n of a pair's row (or column) index, gathered over all pair positions.
   function automatic logic [PAIRS-1:0] field_mask(input int n, input bit hi);
      field_mask = '0;
      for (int a = 0; a < SPRITES - 1; a++)
         for (int b = a + 1; b < SPRITES; b++)
            if ((((hi ? b : a) >> n) & 1) == 1) field_mask |= PAIRS'(1) << pair_index(a, b, SPRITES);
   endfunction
   assign low = mask & (~mask + PAIRS'(1));
   assign any = |mask;
   for (genvar n = 0; n < IDX_W; n++) begin : g_bit
      assign i[n] = |(low & field_mask(n, 1'b0));
      assign j[n] = |(low & field_mask(n, 1'b1));
   end
endmodule

// File: rtl/collision_pair_queue.sv
// collision_pair_queue: snapshots the collision matrix and streams colliding pairs (i<j) over valid/ready.
module collision_pair_queue
   import physics_pkg::*;
#(
   parameter int SPRITES = 9,
   parameter int IDX_W = (SPRITES > 1) ? $clog2(SPRITES) : 1,
   parameter int CNT_W = $clog2(SPRITES * (SPRITES - 1) / 2 + 1)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   input  logic [SPRITES-1:0][SPRITES-1:0] collision,
   output logic                            pair_valid,
   input  logic                            pair_ready,
   output logic [IDX_W-1:0]                pair_a,
   output logic [IDX_W-1:0]                pair_b,
   output logic                            busy,
   output logic                            done,
   output logic [CNT_W-1:0]                pair_count
);
   localparam int PAIRS = SPRITES * (SPRITES - 1) / 2;
   cpq_state_t state, state_n;
   logic [PAIRS-1:0] mask, mask_n, snap;
   logic [CNT_W-1:0] cnt;
   logic any, fire, unused_tri;
   logic [IDX_W-1:0] enc_i, enc_j;
   for (genvar a = 0; a < SPRITES - 1; a++) begin : g_row
      for (genvar b = a + 1; b < SPRITES; b++) begin : g_col
         assign snap[pair_index(a, b, SPRITES)] = collision[a][b];
      end
   end
   assign unused_tri = ^collision;
   pair_priority_encoder #(.SPRITES(SPRITES), .IDX_W(IDX_W), .PAIRS(PAIRS)) u_enc (
      .mask(mask),
      .any(any),
      .i(enc_i),
      .j(enc_j)
   );
   assign fire = pair_valid & pair_ready;
   // Accepting a pair retires the lowest pending bit, which is exactly the presented pair.
   assign mask_n = fire ? (mask & (mask - PAIRS'(1))) : mask;
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = (state == IDLE) ? (start ? SCAN : IDLE) :
                (state == SCAN) ? ((mask_n == '0) ? DONE : SCAN) : IDLE;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         mask <= '0;
         cnt  <= '0;
      end else if (state == IDLE && start) begin
         mask <= snap;
         cnt  <= '0;
      end else if (state == SCAN) begin
         mask <= mask_n;
         if (fire) cnt <= cnt + CNT_W'(1);
      end
   end
   always_comb begin
      pair_valid = (state == SCAN) && any;
      pair_a     = pair_valid ? enc_i : '0;
      pair_b     = pair_valid ? enc_j : '0;
      busy       = state != IDLE;
      done       = state == DONE;
      pair_count = cnt;
   end
endmodule
